clk_sw_ctrl: RTL and testbench



---
 rtl/clk_sw_ctrl_pkg.sv | 17 +
 rtl/clk_sw_rr_arb.sv | 35 +++
 rtl/clk_sw_ctrl.sv | 135 +++++++++++++
 tb/tb_clk_sw_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_sw_ctrl_pkg.sv
// Shared types and constants for the clock-select sequencer.
package clk_sw_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_ACK    = 2'd3
    } state_e;

    localparam int SW_CNT_W = 16;

    function automatic logic [SW_CNT_W-1:0] sat_inc(input logic [SW_CNT_W-1:0] v);
        return (v == '1) ? v : v + SW_CNT_W'(1);
    endfunction

endpackage

// File: rtl/clk_sw_rr_arb.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with wrap.
module clk_sw_rr_arb
    import clk_sw_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_vld,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic           found;
    logic [IDX_W:0] k;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (k >= (IDX_W+1)'(NUM_REQ)) begin
                k = k - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && req_vld[k[IDX_W-1:0]]) begin
                found                = 1'b1;
                gnt[k[IDX_W-1:0]]    = 1'b1;
                gnt_idx              = k[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/clk_sw_ctrl.sv
// Owns the glitch-free clock mux select: arbitrates requesters round-robin,
// switches one at a time and acks only after settle + hold have elapsed.
//   state  | meaning
//   IDLE   | waiting for any req_vld; arbitrate and possibly switch
//   SETTLE | clk_sel changed, waiting for the mux synchronisers
//   HOLD   | minimum dwell before the next arbitration
//   ACK    | ack pulse on the output, advance rr_ptr
module clk_sw_ctrl
    import clk_sw_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter bit DEF_SEL    = 1'b0,
    parameter int SETTLE_CYC = 16,
    parameter int MIN_HOLD   = 8,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req_vld,
    input  logic [NUM_REQ-1:0]  req_sel,
    output logic [NUM_REQ-1:0]  req_ack,
    output logic                clk_sel,
    output logic                busy,
    output logic [SW_CNT_W-1:0] sw_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     timer_q, timer_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 clk_sel_q, clk_sel_d;
    logic                 busy_q, busy_d;
    logic [SW_CNT_W-1:0]  sw_cnt_q, sw_cnt_d;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 enter_ack;

    clk_sw_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_vld (req_vld),
        .rr_ptr  (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_idx_d = gnt_idx_q;
        clk_sel_d = clk_sel_q;
        sw_cnt_d  = sw_cnt_q;
        ack_d     = '0;
        enter_ack = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req_vld) begin
                    gnt_idx_d = arb_idx;
                    if (req_sel[arb_idx] == clk_sel_q) begin
                        state_d = ST_ACK;
                        ack_d   = arb_gnt;
                    end else begin
                        clk_sel_d = req_sel[arb_idx];
                        sw_cnt_d  = sat_inc(sw_cnt_q);
                        timer_d   = CNT_W'(SETTLE_CYC - 1);
                        state_d   = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (timer_q == '0) begin
                    if (MIN_HOLD == 0) begin
                        enter_ack = 1'b1;
                    end else begin
                        timer_d = CNT_W'(MIN_HOLD - 1);
                        state_d = ST_HOLD;
                    end
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (timer_q == '0) begin
                    enter_ack = 1'b1;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            ST_ACK: begin
                rr_ptr_d = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // The ack is registered, so a withdrawal is judged on the cycle we enter ACK.
        if (enter_ack) begin
            state_d           = ST_ACK;
            ack_d[gnt_idx_q]  = req_vld[gnt_idx_q];
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            rr_ptr_q  <= '0;
            gnt_idx_q <= '0;
            ack_q     <= '0;
            clk_sel_q <= DEF_SEL;
            busy_q    <= 1'b0;
            sw_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_idx_q <= gnt_idx_d;
            ack_q     <= ack_d;
            clk_sel_q <= clk_sel_d;
            busy_q    <= busy_d;
            sw_cnt_q  <= sw_cnt_d;
        end
    end

    assign req_ack = ack_q;
    assign clk_sel = clk_sel_q;
    assign busy    = busy_q;
    assign sw_cnt  = sw_cnt_q;

endmodule

// File: tb/tb_clk_sw_ctrl.sv
// Directed bench for clk_sw_ctrl with a scoreboard of expected ack events.
module tb_clk_sw_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_vld = '0;
    logic [3:0]  req_sel = '0;
    logic [3:0]  req_ack;
    logic        clk_sel;
    logic        busy;
    logic [15:0] sw_cnt;

    logic [3:0]  req_vld1 = '0;
    logic [3:0]  req_sel1 = '0;
    logic [3:0]  req_ack1;
    logic        clk_sel1;
    logic        busy1;
    logic [15:0] sw_cnt1;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0]  ack;
        int          cyc;
        logic        sel;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clk_sw_ctrl #(.NUM_REQ(4), .DEF_SEL(1'b0), .SETTLE_CYC(16), .MIN_HOLD(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_sel(req_sel),
        .req_ack(req_ack), .clk_sel(clk_sel), .busy(busy), .sw_cnt(sw_cnt)
    );

    clk_sw_ctrl #(.NUM_REQ(4), .DEF_SEL(1'b1), .SETTLE_CYC(16), .MIN_HOLD(8), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld1), .req_sel(req_sel1),
        .req_ack(req_ack1), .clk_sel(clk_sel1), .busy(busy1), .sw_cnt(sw_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] ack, input int at, input logic sel, input logic [15:0] cnt);
        exp_t e;
        e.ack = ack; e.cyc = at; e.sel = sel; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input string tag);
        exp_t e;
        bit   got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ack !== 4'b0000) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_ack_seen"}, 32'(got), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (got && sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_ack"},     32'(req_ack), 32'(e.ack));
            chk({tag, "_ack_cyc"}, 32'(cyc),     32'(e.cyc));
            chk({tag, "_clk_sel"}, 32'(clk_sel), 32'(e.sel));
            chk({tag, "_sw_cnt"},  32'(sw_cnt),  32'(e.cnt));
            chk({tag, "_busy"},    32'(busy),    32'd1);
        end
    endtask

    task automatic drop(input logic [3:0] mask);
        @(posedge clk);
        #1 req_vld = req_vld & ~mask;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // reset state on both instances
        repeat (3) @(negedge clk);
        chk("rst_clk_sel",  32'(clk_sel),  32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_sw_cnt",   32'(sw_cnt),   32'd0);
        chk("rst_ack",      32'(req_ack),  32'd0);
        chk("rst1_clk_sel", 32'(clk_sel1), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst1_busy",    32'(busy1),    32'd0);
        chk("rst1_clk_sel_run", 32'(clk_sel1), 32'd1);

        // same-select request: ack next cycle, no switch
        c = cyc; req_vld = 4'b0010; req_sel = 4'b0000;
        push_exp(4'b0010, c + 1, 1'b0, 16'd0);
        wait_ack("same");
        drop(4'b0010);
        @(negedge clk);
        chk("same_busy_after", 32'(busy), 32'd0);

        // switch 0 -> 1 via requester 2
        c = cyc; req_vld = 4'b0100; req_sel = 4'b0100;
        push_exp(4'b0100, c + 25, 1'b1, 16'd1);
        @(negedge clk);
        chk("sw01_clk_sel_t1", 32'(clk_sel), 32'd1);
        chk("sw01_busy_t1",    32'(busy),    32'd1);
        chk("sw01_noack_t1",   32'(req_ack), 32'd0);
        wait_ack("sw01");
        drop(4'b0100);
        @(negedge clk);
        chk("sw01_busy_after", 32'(busy), 32'd0);

        // switch 1 -> 0 via requester 3, rr_ptr wraps to 0
        c = cyc; req_vld = 4'b1000; req_sel = 4'b0000;
        push_exp(4'b1000, c + 25, 1'b0, 16'd2);
        wait_ack("sw10");
        drop(4'b1000);

        // all four at once, alternating targets
        @(negedge clk);
        c = cyc; req_vld = 4'b1111; req_sel = 4'b0101;
        push_exp(4'b0001, c + 25,  1'b1, 16'd3);
        push_exp(4'b0010, c + 51,  1'b0, 16'd4);
        push_exp(4'b0100, c + 77,  1'b1, 16'd5);
        push_exp(4'b1000, c + 103, 1'b0, 16'd6);
        wait_ack("burst0"); drop(4'b0001);
        wait_ack("burst1"); drop(4'b0010);
        wait_ack("burst2"); drop(4'b0100);
        wait_ack("burst3"); drop(4'b1000);

        // requester 0 withdraws during SETTLE
        @(negedge clk);
        c = cyc; req_vld = 4'b0001; req_sel = 4'b0001;
        @(negedge clk);
        chk("wd_clk_sel_t1", 32'(clk_sel), 32'd1);
        wait_cyc(c + 5);
        req_vld = 4'b0000;
        while (cyc < c + 28) begin
            @(negedge clk);
            chk("wd_no_ack", 32'(req_ack), 32'd0);
        end
        chk("wd_busy",    32'(busy),    32'd0);
        chk("wd_clk_sel", 32'(clk_sel), 32'd1);
        chk("wd_sw_cnt",  32'(sw_cnt),  32'd7);
        // rr_ptr advanced past 0, so requester 1 wins over 0
        c = cyc; req_vld = 4'b0011; req_sel = 4'b0010;
        push_exp(4'b0010, c + 1,  1'b1, 16'd7);
        push_exp(4'b0001, c + 27, 1'b0, 16'd8);
        wait_ack("wd_next1"); drop(4'b0010);
        wait_ack("wd_next0"); drop(4'b0001);

        // reset asserted in HOLD
        @(negedge clk);
        c = cyc; req_vld = 4'b0100; req_sel = 4'b0100;
        @(negedge clk);
        chk("rh_clk_sel_t1", 32'(clk_sel), 32'd1);
        chk("rh_sw_cnt_t1",  32'(sw_cnt),  32'd9);
        wait_cyc(c + 20);
        rst_n = 1'b0;
        #1;
        chk("rh_clk_sel", 32'(clk_sel), 32'd0);
        chk("rh_busy",    32'(busy),    32'd0);
        chk("rh_sw_cnt",  32'(sw_cnt),  32'd0);
        chk("rh_ack",     32'(req_ack), 32'd0);
        chk("rh1_clk_sel", 32'(clk_sel1), 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("rh_ack_in_rst", 32'(req_ack), 32'd0);
        end
        chk("rh_sb_empty", 32'(sb.size()), 32'd0);
        rst_n = 1'b1;
        c = cyc; req_vld = 4'b0101; req_sel = 4'b0101;
        push_exp(4'b0001, c + 25, 1'b1, 16'd1);
        push_exp(4'b0100, c + 27, 1'b1, 16'd1);
        wait_ack("rh_rearb0"); drop(4'b0001);
        wait_ack("rh_rearb2"); drop(4'b0100);
        @(negedge clk);
        chk("end_busy",     32'(busy),      32'd0);
        chk("end_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
